// File: rtl/instr_fetch_unit_if.sv
// Bundle of the fetch unit's memory read port, IR load port, redirect
// input and observation outputs.
// master: the fetch unit. slave: the memory/IR/branch side.
interface instr_fetch_unit_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16
);
    // Memory read handshake. The requester raises mem_req_o with a stable
    // mem_addr_o and keeps both unchanged until it sees mem_ack_i=1 at a
    // posedge. mem_data_i is valid in that same ack cycle. A raised request
    // is never withdrawn, and at most one request is outstanding.
    logic                  mem_req_o;
    logic [ADDR_WIDTH-1:0] mem_addr_o;
    logic                  mem_ack_i;
    logic [DATA_WIDTH-1:0] mem_data_i;

    // IR load port. ir_ld_no is low for exactly one cycle per word.
    logic                  ir_ready_i;
    logic                  ir_ld_no;
    logic [DATA_WIDTH-1:0] ir_data_o;
    logic [ADDR_WIDTH-1:0] ir_pc_o;

    // Control flow change.
    logic                  redirect_i;
    logic [ADDR_WIDTH-1:0] redirect_addr_i;

    // Observation.
    logic [1:0]            fifo_count_o;
    logic [1:0]            fetch_state;   // debug: 0=FETCH 1=WAIT 2=DISCARD

    modport master (
        output mem_req_o, mem_addr_o,
        input  mem_ack_i, mem_data_i,
        input  ir_ready_i,
        output ir_ld_no, ir_data_o, ir_pc_o,
        input  redirect_i, redirect_addr_i,
        output fifo_count_o, fetch_state
    );

    modport slave (
        input  mem_req_o, mem_addr_o,
        output mem_ack_i, mem_data_i,
        output ir_ready_i,
        input  ir_ld_no, ir_data_o, ir_pc_o,
        output redirect_i, redirect_addr_i,
        input  fifo_count_o, fetch_state
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage feeding the instruction register.
// Walks the PC, reads words over a req/ack handshake, buffers them in a
// 2-entry prefetch FIFO and hands each word to the IR with a one-cycle
// active-low load strobe. A redirect flushes the FIFO and restarts fetching
// at the new address; an in-flight read is completed and its data dropped.
// Optional feature macro: FETCH_STATS_EN adds stall_cnt_o, a saturating
// count of cycles spent waiting on memory with an empty FIFO.
module instr_fetch_unit #(
    parameter int                    DATA_WIDTH   = 16,
    parameter int                    ADDR_WIDTH   = 16,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic               clk_i,
    input  logic               reset_ni,
    instr_fetch_unit_if.master bus
`ifdef FETCH_STATS_EN
    ,
    output logic [15:0]        stall_cnt_o
`endif
);

    localparam int EW = ADDR_WIDTH + DATA_WIDTH;

    typedef enum logic [1:0] {
        S_FETCH   = 2'd0,
        S_WAIT    = 2'd1,
        S_DISCARD = 2'd2
    } state_t;

    state_t                state_q;
    logic [ADDR_WIDTH-1:0] pc_q;
    logic                  mem_req_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;

    // FIFO slots hold {pc, word}; slot0 is always the head.
    logic [EW-1:0]         slot0_q;
    logic [EW-1:0]         slot1_q;
    logic [1:0]            count_q;

    logic                  ir_ld_n_q;
    logic [DATA_WIDTH-1:0] ir_data_q;
    logic [ADDR_WIDTH-1:0] ir_pc_q;

    logic                  do_pop;
    logic                  do_push;
    logic [EW-1:0]         new_entry;

    // Pop needs a word already held (so a push is visible one edge later);
    // push only for a live (non-discarded) read that is not being flushed.
    always_comb begin
        do_pop    = (count_q != 2'd0) && bus.ir_ready_i && !bus.redirect_i;
        do_push   = (state_q == S_WAIT) && bus.mem_ack_i && !bus.redirect_i;
        new_entry = {pc_q, bus.mem_data_i};
    end

    // Fetch FSM: issues one request at a time, tracks the PC and handles
    // redirects, including dropping data of a read already in flight.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q    <= S_FETCH;
            pc_q       <= RESET_VECTOR;
            mem_req_q  <= 1'b0;
            mem_addr_q <= RESET_VECTOR;
        end else begin
            case (state_q)
                S_FETCH: begin
                    // A request reserves the free slot, so a full FIFO blocks it.
                    if (!bus.redirect_i && (count_q != 2'd2)) begin
                        mem_req_q  <= 1'b1;
                        mem_addr_q <= pc_q;
                        state_q    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (bus.mem_ack_i) begin
                        mem_req_q <= 1'b0;
                        pc_q      <= pc_q + 1'b1;
                        state_q   <= S_FETCH;
                    end else if (bus.redirect_i) begin
                        state_q <= S_DISCARD;
                    end
                end
                S_DISCARD: begin
                    if (bus.mem_ack_i) begin
                        mem_req_q <= 1'b0;
                        state_q   <= S_FETCH;
                    end
                end
                default: begin
                    mem_req_q <= 1'b0;
                    state_q   <= S_FETCH;
                end
            endcase
            // Redirect overrides any PC increment made above.
            if (bus.redirect_i) begin
                pc_q <= bus.redirect_addr_i;
            end
        end
    end

    // Prefetch FIFO and IR load port: flush on redirect, otherwise push/pop.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            slot0_q   <= '0;
            slot1_q   <= '0;
            count_q   <= 2'd0;
            ir_ld_n_q <= 1'b1;
            ir_data_q <= '0;
            ir_pc_q   <= '0;
        end else if (bus.redirect_i) begin
            count_q   <= 2'd0;
            ir_ld_n_q <= 1'b1;
        end else begin
            ir_ld_n_q <= !do_pop;
            if (do_pop) begin
                ir_data_q <= slot0_q[DATA_WIDTH-1:0];
                ir_pc_q   <= slot0_q[EW-1:DATA_WIDTH];
            end
            case ({do_push, do_pop})
                2'b10: begin
                    if (count_q == 2'd0) begin
                        slot0_q <= new_entry;
                    end else begin
                        slot1_q <= new_entry;
                    end
                    count_q <= count_q + 2'd1;
                end
                2'b01: begin
                    slot0_q <= slot1_q;
                    count_q <= count_q - 2'd1;
                end
                2'b11: begin
                    if (count_q == 2'd1) begin
                        slot0_q <= new_entry;
                    end else begin
                        slot0_q <= slot1_q;
                        slot1_q <= new_entry;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef FETCH_STATS_EN
    logic [15:0] stall_cnt_q;

    // Count cycles starved on memory: read outstanding, nothing buffered.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            stall_cnt_q <= 16'd0;
        end else if ((count_q == 2'd0) && (state_q != S_FETCH) &&
                     (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`endif

    assign bus.mem_req_o    = mem_req_q;
    assign bus.mem_addr_o   = mem_addr_q;
    assign bus.ir_ld_no     = ir_ld_n_q;
    assign bus.ir_data_o    = ir_data_q;
    assign bus.ir_pc_o      = ir_pc_q;
    assign bus.fifo_count_o = count_q;
    assign bus.fetch_state  = state_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Testbench for instr_fetch_unit: randomized memory/IR/redirect stimulus,
// a queue-based reference model and a monitor that compares every cycle.
module tb_instr_fetch_unit;

    localparam int DW = 16;
    localparam int AW = 16;
    localparam int EW = AW + DW;

    logic clk = 1'b0;
    logic reset_ni;

    always #5 clk = ~clk;

    instr_fetch_unit_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

`ifdef FETCH_STATS_EN
    logic [15:0] stall_cnt;
`endif

    instr_fetch_unit #(
        .DATA_WIDTH  (DW),
        .ADDR_WIDTH  (AW),
        .RESET_VECTOR(16'h0000)
    ) dut (
        .clk_i   (clk),
        .reset_ni(reset_ni),
        .bus     (bus.master)
`ifdef FETCH_STATS_EN
        ,
        .stall_cnt_o(stall_cnt)
`endif
    );

    // Reference model: words buffered in the fetch unit, words due on the
    // IR port after the next edge, and the outstanding read.
    logic [EW-1:0] fifo_q[$];
    logic [EW-1:0] exp_q[$];
    logic [AW-1:0] m_pc;
    logic [AW-1:0] m_req_addr;
    bit            m_out;
    bit            m_discard;
    int            m_stall;
    bit            mon_en;
    int            n_tests;
    int            n_fail;
    logic [EW-1:0] mon_e;
    logic [AW-1:0] rnd_addr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        fifo_q.delete();
        exp_q.delete();
        m_pc       = 16'h0000;
        m_req_addr = 16'h0000;
        m_out      = 1'b0;
        m_discard  = 1'b0;
        m_stall    = 0;
    endtask

    task automatic clear_inputs();
        bus.mem_ack_i       = 1'b0;
        bus.mem_data_i      = '0;
        bus.ir_ready_i      = 1'b0;
        bus.redirect_i      = 1'b0;
        bus.redirect_addr_i = '0;
    endtask

    // Drive one cycle of inputs, advance the model to the effect of the
    // coming edge, then wait past that edge.
    task automatic drive_cycle(input bit rdy, input bit redir,
                               input logic [AW-1:0] raddr, input int ack_pct);
        bit            ack;
        logic [DW-1:0] d;
        int            sz;
        bit            out;
        ack = m_out && ($urandom_range(0, 99) < ack_pct);
        d   = DW'($urandom);
        bus.ir_ready_i      = rdy;
        bus.redirect_i      = redir;
        bus.redirect_addr_i = raddr;
        bus.mem_ack_i       = ack;
        bus.mem_data_i      = d;

        sz  = fifo_q.size();
        out = m_out;
        if (sz == 0 && out && m_stall < 65535) m_stall++;
        if (redir) begin
            fifo_q.delete();
            m_pc = raddr;
            if (out) begin
                if (ack) begin
                    m_out     = 1'b0;
                    m_discard = 1'b0;
                end else begin
                    m_discard = 1'b1;
                end
            end
        end else begin
            if (sz > 0 && rdy) exp_q.push_back(fifo_q.pop_front());
            if (out && ack) begin
                if (!m_discard) begin
                    fifo_q.push_back({m_req_addr, d});
                    m_pc = m_pc + 16'd1;
                end
                m_out     = 1'b0;
                m_discard = 1'b0;
            end else if (!out && sz < 2) begin
                m_out      = 1'b1;
                m_req_addr = m_pc;
            end
        end
        @(posedge clk);
        #2;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " mem_req"},  32'(bus.mem_req_o),    32'd0);
        check({tag, " mem_addr"}, 32'(bus.mem_addr_o),   32'h0000);
        check({tag, " ir_ld_no"}, 32'(bus.ir_ld_no),     32'd1);
        check({tag, " ir_data"},  32'(bus.ir_data_o),    32'd0);
        check({tag, " ir_pc"},    32'(bus.ir_pc_o),      32'd0);
        check({tag, " count"},    32'(bus.fifo_count_o), 32'd0);
`ifdef FETCH_STATS_EN
        check({tag, " stall"},    32'(stall_cnt),        32'd0);
`endif
    endtask

    // Monitor: after every edge compare IR port, FIFO level and memory port.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (mon_en) begin
                if (exp_q.size() > 0) begin
                    mon_e = exp_q.pop_front();
                    check("ir_ld_no load", 32'(bus.ir_ld_no), 32'd0);
                    check("ir_data", 32'(bus.ir_data_o), 32'(mon_e[DW-1:0]));
                    check("ir_pc", 32'(bus.ir_pc_o), 32'(mon_e[EW-1:DW]));
                end else begin
                    check("ir_ld_no idle", 32'(bus.ir_ld_no), 32'd1);
                end
                check("fifo_count", 32'(bus.fifo_count_o), 32'(fifo_q.size()));
                check("mem_req", 32'(bus.mem_req_o), 32'(m_out));
                if (m_out) check("mem_addr", 32'(bus.mem_addr_o), 32'(m_req_addr));
`ifdef FETCH_STATS_EN
                check("stall_cnt", 32'(stall_cnt), 32'(m_stall));
`endif
            end
        end
    end

    // Stimulus sequence.
    initial begin
        n_tests = 0;
        n_fail  = 0;
        mon_en  = 1'b0;
        reset_ni = 1'b0;
        clear_inputs();
        model_reset();
        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        reset_ni = 1'b1;
        mon_en   = 1'b1;

        // Streaming: ack every cycle, IR always ready.
        repeat (20) drive_cycle(1'b1, 1'b0, '0, 100);

        // IR stalled: FIFO fills, requests stop; then back-to-back pops.
        repeat (10) drive_cycle(1'b0, 1'b0, '0, 100);
        check("full count", 32'(bus.fifo_count_o), 32'd2);
        check("full no req", 32'(bus.mem_req_o), 32'd0);
        repeat (6) drive_cycle(1'b1, 1'b0, '0, 100);

        // Redirect while a read is outstanding; late ack must be dropped.
        for (int i = 0; i < 8 && !m_out; i++) drive_cycle(1'b1, 1'b0, '0, 0);
        check("reach wait", 32'(bus.mem_req_o), 32'd1);
        drive_cycle(1'b1, 1'b1, 16'h1234, 0);
        repeat (2) drive_cycle(1'b1, 1'b0, '0, 0);
        drive_cycle(1'b1, 1'b0, '0, 100);
        check("discard count", 32'(bus.fifo_count_o), 32'd0);
        repeat (8) drive_cycle(1'b1, 1'b0, '0, 100);

        // Redirect on the same edge as an ack and a pending pop.
        for (int i = 0; i < 20 && !(m_out && fifo_q.size() > 0); i++)
            drive_cycle(1'b0, 1'b0, '0, 100);
        check("pending pop setup", 32'(bus.fifo_count_o != 2'd0 && bus.mem_req_o), 32'd1);
        drive_cycle(1'b1, 1'b1, 16'h0ABC, 100);
        check("redir no strobe", 32'(bus.ir_ld_no), 32'd1);
        repeat (6) drive_cycle(1'b1, 1'b0, '0, 100);

        // Redirect to the top of the address space: wraps to 0000.
        drive_cycle(1'b1, 1'b1, 16'hFFFF, 100);
        repeat (10) drive_cycle(1'b1, 1'b0, '0, 100);

        // Randomized traffic.
        repeat (1500) begin
            rnd_addr = ($urandom_range(0, 3) == 0) ? 16'hFFFE : AW'($urandom);
            drive_cycle($urandom_range(0, 99) < 70, $urandom_range(0, 99) < 4,
                        rnd_addr, $urandom_range(0, 100));
        end

        // Asynchronous reset while a read is outstanding.
        for (int i = 0; i < 8 && !m_out; i++) drive_cycle(1'b1, 1'b0, '0, 0);
        check("pre-reset wait", 32'(bus.mem_req_o), 32'd1);
        #1;
        mon_en   = 1'b0;
        reset_ni = 1'b0;
        #1;
        check_reset_outputs("async reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        clear_inputs();
        model_reset();
        reset_ni = 1'b1;
        mon_en   = 1'b1;
        repeat (12) drive_cycle(1'b1, 1'b0, '0, 100);
        drive_cycle(1'b0, 1'b0, '0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
